// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for data_mem_responder: load/store funct3 types, FSM states,
// wait-state counter width and access-size helpers.
package data_mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Wide enough for WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    function automatic acc_size_e access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // Unsigned variants only make sense for loads.
    function automatic logic type_legal(input logic write, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !write;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (access_size(funct3))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-enable generation, store-lane shifting and load extraction/extension
// for one 32-bit word; misaligned offsets are forced down to the access size.
module dmem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    acc_size_e   size;
    logic [1:0]  off;
    logic [4:0]  shamt;
    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        size        = access_size(funct3);
        off         = 2'b00;
        byte_en     = 4'b1111;
        case (size)
            SZ_BYTE: begin
                off     = addr_lo;
                byte_en = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                off     = {addr_lo[1], 1'b0};
                byte_en = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
        shamt       = {off, 3'b000};
        wdata_lanes = wdata << shamt;
        shifted     = word >> shamt;
        case (size)
            SZ_BYTE: rdata_ext = funct3[2] ? {24'b0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: rdata_ext = funct3[2] ? {16'b0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_ext = word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory with valid/ready request and response channels and
// WAIT_CYCLES access wait states. Define MISALIGN_TRAP_EN to reject misaligned H/W accesses.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_type,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lat_write;
    logic [IDX_W+1:0] lat_addr;
    logic [31:0]      lat_wdata;
    logic [2:0]       lat_type;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept, commit;
    logic             cur_write, cur_err;
    logic [IDX_W+1:0] cur_addr;
    logic [31:0]      cur_wdata;
    logic [2:0]       cur_type;
    logic [IDX_W-1:0] cur_idx;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lanes, rdata_ext;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign accept    = req_valid && req_ready;

    // With zero wait states the live request commits on its own accept edge.
    assign cur_write = (state_q == ST_IDLE) ? req_write                : lat_write;
    assign cur_addr  = (state_q == ST_IDLE) ? req_addr[IDX_W+1:0]      : lat_addr;
    assign cur_wdata = (state_q == ST_IDLE) ? req_wdata                : lat_wdata;
    assign cur_type  = (state_q == ST_IDLE) ? req_type                 : lat_type;
    assign cur_idx   = cur_addr[IDX_W+1:2];

    assign commit = rst_n &&
                    (((state_q == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == ST_ACCESS) && (cnt_q == '0)));

`ifdef MISALIGN_TRAP_EN
    assign cur_err = !type_legal(cur_write, cur_type) || is_misaligned(cur_type, cur_addr[1:0]);
`else
    assign cur_err = !type_legal(cur_write, cur_type);
`endif

    dmem_lane_align u_align (
        .funct3      (cur_type),
        .addr_lo     (cur_addr[1:0]),
        .wdata       (cur_wdata),
        .word        (mem[cur_idx]),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext)
    );

    // NOTE: storage has no reset; clearing a RAM array would force it into flops.
    always_ff @(posedge clk) begin
        if (commit && cur_write && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[cur_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_type  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr[IDX_W+1:0];
                        lat_wdata <= req_wdata;
                        lat_type  <= req_type;
                        cnt_q     <= CNT_LOAD;
                        state_q   <= (WAIT_CYCLES == 0) ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) state_q <= ST_RESP;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (commit) begin
                rsp_rdata <= (cur_err || cur_write) ? 32'h0 : rdata_ext;
                rsp_err   <= cur_err;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by
// randomized traffic compared against a byte-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int WAIT  = 1;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_type;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] bm [BYTES];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_type  (req_type),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural model: memory as a flat byte array, address wraps modulo its size.
    task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] ty, output logic [31:0] rd, output logic er);
        int a, sz;
        logic [31:0] v;
        rd = 32'h0;
        er = 1'b0;
        if (ty == 3 || ty == 6 || ty == 7 || (wr && ty >= 4)) begin
            er = 1'b1;
            return;
        end
        sz = (ty == 0 || ty == 4) ? 1 : (ty == 1 || ty == 5) ? 2 : 4;
        a  = int'(addr % BYTES);
        if (a % sz != 0) begin
`ifdef MISALIGN_TRAP_EN
            er = 1'b1;
            return;
`else
            a = a - (a % sz);
`endif
        end
        if (wr) begin
            for (int i = 0; i < sz; i++) bm[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = bm[a + i];
            if (ty < 4 && sz < 4 && v[8*sz - 1]) begin
                for (int i = sz * 8; i < 32; i++) v[i] = 1'b1;
            end
            rd = v;
        end
    endtask

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] ty, output logic [31:0] rd, output logic er,
                          output int lat);
        int n = 0;
        rsp_ready = 1'b1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_type  = ty;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        check("busy_req_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        check("rsp_drop", rsp_valid, 1'b0);
        check("ready_back", req_ready, 1'b1);
    endtask

    task automatic dir(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] ty,
                       input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] unused_rd, rd;
        logic        unused_er, er;
        int          lat;
        model(wr, addr, wd, ty, unused_rd, unused_er);
        do_req(wr, addr, wd, ty, rd, er, lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, {31'b0, er}, {31'b0, exp_er});
        check({tag, "_lat"}, lat, WAIT + 1);
    endtask

    task automatic rnd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] ty);
        logic [31:0] exp_rd, rd;
        logic        exp_er, er;
        int          lat;
        model(wr, addr, wd, ty, exp_rd, exp_er);
        do_req(wr, addr, wd, ty, rd, er, lat);
        check("rnd_rdata", rd, exp_rd);
        check("rnd_err", {31'b0, er}, {31'b0, exp_er});
        check("rnd_lat", lat, WAIT + 1);
    endtask

    initial begin
        logic [31:0] held, r;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_type = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);

        dir("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
        dir("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
        dir("lb13", 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);
        dir("lbu13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0);
        dir("lh10", 1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
        dir("lhu12", 1'b0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);
`ifdef MISALIGN_TRAP_EN
        dir("lh11", 1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1);
`else
        dir("lh11", 1'b0, 32'h11, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
`endif
        dir("sb11", 1'b1, 32'h11, 32'h55, 3'b000, 32'h0, 1'b0);
        dir("lw10_sb", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);
        dir("lw_alias", 1'b0, 32'h10 + BYTES, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);

        // Back-pressure: response held, competing store must be ignored.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_type = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0BADF00D;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        held = rsp_rdata;
        check("stall_first", held, 32'hDEAD55EF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_rdata", rsp_rdata, held);
            check("stall_ready", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_done_valid", rsp_valid, 1'b0);
        dir("lw_after_stall", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);

        dir("ld_t011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
        dir("st_t011", 1'b1, 32'h10, 32'h11111111, 3'b011, 32'h0, 1'b1);
        dir("st_tbu", 1'b1, 32'h10, 32'h22222222, 3'b100, 32'h0, 1'b1);
        dir("lw_no_write", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);

        // Reset while the store sits in ACCESS: it must never land.
        dir("sw20_prior", 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_type = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("acc_ready", req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_acc_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", req_ready, 1'b1);
        check("post_rst_valid", rsp_valid, 1'b0);
        check("post_rst_rdata", rsp_rdata, 32'h0);
        dir("lw20_prior", 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);

        // Randomized traffic over a preloaded 256-byte window with random alias bits.
        for (int w = 0; w < 64; w++) rnd(1'b1, 32'(w * 4), $urandom, 3'b010);
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            rnd(1'($urandom_range(0, 1)), (r & 32'hFFFF_FC00) | 32'($urandom_range(0, 255)),
                $urandom, 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two).
REQ-002 Parameter WAIT_CYCLES, default 1, access wait states inserted between accept and response (0 to 15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 req_type  input  3  RISC-V funct3 (lorbtype): 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator accepts response.
REQ-013 rsp_rdata  output  32  load result, extended per req_type; 0 for stores and errors.
REQ-014 rsp_err  output  1  request rejected (illegal type, or misaligned when trap enabled).

Function
REQ-015 FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-016 Handshake req_valid && req_ready latches write, addr, wdata, type; IDLE -> ACCESS, or IDLE -> RESP when WAIT_CYCLES = 0.
REQ-017 ACCESS holds exactly WAIT_CYCLES cycles via down-counter, then -> RESP; request-to-rsp_valid latency = WAIT_CYCLES + 1 cycles.
REQ-018 Stores commit to storage on the ACCESS -> RESP (or IDLE -> RESP) transition edge, using byte enables: B one lane at addr[1:0], H lanes addr[1]*2..+1, W all four.
REQ-019 Loads read the word on that same edge; B/H sign-extend, BU/HU zero-extend, W unmodified; result registered into rsp_rdata.
REQ-020 Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing wrap, no error).
REQ-021 req_type 011, 110, 111, or store with type 100/101: rsp_err = 1, no storage change, rsp_rdata = 0.
REQ-022 RESP holds rsp_valid, rsp_rdata, rsp_err stable until rsp_valid && rsp_ready; then -> IDLE, rsp_valid = 0 next cycle.
REQ-023 No new request accepted in the cycle the response completes (req_ready rises the following cycle); max throughput one request per WAIT_CYCLES + 2 cycles.
REQ-024 req_* inputs ignored outside IDLE.

Reset
REQ-025 rst_n low: state IDLE, counter 0, req_ready 1 after release, rsp_valid 0, rsp_rdata 0, rsp_err 0, latched request cleared.
REQ-026 Reset during ACCESS drops the pending request; an uncommitted store is never written.
REQ-027 Storage contents are not reset.

Configuration
REQ-028 Macro MISALIGN_TRAP_EN defined: H/HU with addr[0] = 1 or W with addr[1:0] != 0 yields rsp_err = 1, no write, rsp_rdata = 0.
REQ-029 MISALIGN_TRAP_EN undefined: misaligned accesses force offset bits to zero (H: addr[0] cleared, W: addr[1:0] cleared), rsp_err = 0.

Structure
REQ-030 Shared package holds the funct3 load/store type encodings, FSM state enum, and WAIT_CYCLES counter width constant.
REQ-031 One sub-module, dmem_lane_align: combinational byte-enable generation, store-lane shifting and load extraction/extension.

Verification
REQ-032 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid exactly WAIT_CYCLES+1 cycles after accept.
REQ-033 After REQ-032 state: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-034 SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF (other lanes untouched).
REQ-035 LH 0x11 -> with MISALIGN_TRAP_EN rsp_err 1, rsp_rdata 0; without, rsp_rdata 0xFFFFBEEF (after REQ-032 state), rsp_err 0.
REQ-036 Hold rsp_ready 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0, new req_valid ignored; req_type 011 -> rsp_err 1, no write.
REQ-037 Assert rst_n low during ACCESS of SW 0x20 data 0x12345678 -> rsp_valid 0, later LW 0x20 returns prior contents.
